bit_index_encoder: RTL

Parametrised, registered priority encoder that takes a WIDTH-bit request vector and streams the index of every set bit, one index per handshake, in priority order. It generalises the fixed 4-to-2 encoder to any power-of-two width, selectable scan direction, an explicit "no bits set" result, and valid/ready flow control on both sides. It sits between request-collecting logic (switches, IRQ lines, channel-busy flags) and any consumer that services one channel at a time.

---
 rtl/bit_index_encoder_pkg.sv | 22 ++
 rtl/prio_enc_comb.sv | 28 ++
 rtl/bit_index_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/bit_index_encoder_pkg.sv
// Shared types for the bit index encoder: FSM state encoding and a constant log2 helper.
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Constant-foldable ceil(log2(value)); usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: index of the lowest (or highest) set bit of vec.
module prio_enc_comb
    import enc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDXW     = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             found
);

    // Scan from the low-priority end so the last hit written is the winner.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (vec[i]) idx = IDXW'(i);
            end else begin
                if (vec[WIDTH-1-i]) idx = IDXW'(WIDTH - 1 - i);
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/bit_index_encoder.sv
// Registered priority encoder streaming the index of every set bit of an accepted
// request vector, one index per output handshake, in the configured priority order.
module bit_index_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDXW:0]    out_count,
    output state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, and the producer holds its payload until
    // the transfer. in_ready is high only in IDLE, out_valid only in SCAN.

    state_t           state;
    state_t           state_nxt;
    logic             rdy_q;
    logic [WIDTH-1:0] mask;
    logic [IDXW:0]    count_q;
    logic [IDXW:0]    popcnt;
    logic [IDXW-1:0]  enc_idx;
    logic             enc_found;
    logic             single;
    logic             accept;
    logic             xfer;

    prio_enc_comb #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec   (mask),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // Zero or exactly one bit left in the mask means this beat is the last one.
    assign single = ((mask & (mask - WIDTH'(1))) == '0);

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt = popcnt + {{IDXW{1'b0}}, in_data[i]};
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        accept    = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rdy_q;
                accept   = rdy_q & in_valid;
                if (accept) state_nxt = SCAN;
            end
            SCAN: begin
                out_valid = 1'b1;
                out_last  = single;
                out_none  = ~enc_found;
                xfer      = out_ready;
                if (xfer && single) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdy_q holds in_ready low during the reset cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            mask    <= '0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            if (accept) begin
                mask    <= in_data;
                count_q <= popcnt;
            end else if (xfer) begin
                mask[enc_idx] <= 1'b0;
            end
        end
    end

    assign out_idx   = enc_idx;
    assign out_count = count_q;
    assign dbg_state = state;

endmodule
